wb_regfile_scoreboard: RTL and testbench
========================================

// Module: wb_regfile_scoreboard
// PURPOSE
// - Write-back end of the MEM->WB pipe register. Accepts the registered WB
//   bundle, selects the write-back value, and writes the 16x32 register file.
// - Serves two ID-stage read ports, with same-cycle write-through bypass.
// - Keeps a per-register scoreboard of in-flight writers.
// - Raises a RAW hazard to the ID stage when a source register is still pending.
// PARAMETERS
// - DATA_W  32  register / datapath width
// - ADDR_W  4   register index width (2**ADDR_W registers)
// - CNT_W   2   per-register in-flight counter width (max 3 writers: EX, MEM, WB)
// PORTS
// - clk          in   1       single clock; all state updates on posedge
// - rst          in   1       asynchronous, active-low reset (asserted when 0)
// - WB_EN        in   1       write-back enable from MEM->WB pipe register
// - MEM_R_EN     in   1       1: write MEM_Result; 0: write ALU_Res
// - ALU_Res      in   DATA_W  ALU result
// - MEM_Result   in   DATA_W  load data
// - Dest         in   ADDR_W  write-back destination
// - issue_en     in   1       ID issues an instruction this cycle (not stalled)
// - issue_wb     in   1       issued instruction will write back
// - issue_dest   in   ADDR_W  destination of the issued instruction
// - src1, src2   in   ADDR_W  ID read addresses
// - src1_v       in   1       src1 is used by the ID instruction
// - src2_v       in   1       src2 is used by the ID instruction
// - rd1, rd2     out  DATA_W  read data (combinational)
// - wb_value     out  DATA_W  selected write-back value (combinational)
// - hazard       out  1       ID must stall; issue_en must be 0 while hazard=1
// BEHAVIOUR
// - Reset (rst=0, async):
//   - All 16 registers and all counters cleared to 0.
//   - Therefore rd1 = rd2 = 0 and hazard = 0.
//   - wb_value follows its inputs.
// - wb_value = MEM_R_EN ? MEM_Result : ALU_Res, regardless of WB_EN.
// - Write: on posedge with WB_EN=1, regs[Dest] <= wb_value. One write per cycle.
// - Read: rdN = (WB_EN && Dest==srcN) ? wb_value : regs[srcN].
//   - Write-through is zero latency: same-cycle write is visible to ID.
// - Counter cnt[r], at posedge:
//   - +1 if (issue_en && issue_wb && issue_dest==r && !hazard).
//   - -1 if (WB_EN && Dest==r).
//   - Both events on the same r: cnt unchanged.
// - Boundaries:
//   - Increment at cnt=3 or decrement at cnt=0 is a protocol error.
//   - Counter saturates (holds) in that case; simulation assertion fires.
// - Hazard:
//   - pendN = srcN_v && (cnt[srcN] - (WB_EN && Dest==srcN)) != 0.
//   - A last writer retiring this cycle is bypassed and is not a hazard.
//   - hazard = pend1 | pend2. Purely combinational, no added latency.
// - Mid-operation reset: all in-flight tracking is discarded. The pipeline is
//   reset by the same rst, so no stale WB_EN can follow.
// - No register index is special. The PC is not held here.
// STRUCTURE
// - Shared package:
//   - REG_CNT = 16, DATA_W, ADDR_W, CNT_W.
//   - wb_bundle_t {wb_en, mem_r_en, alu_res, mem_result, dest}, shared with the
//     MEM->WB pipe register.
// - One sub-module: wb_scoreboard_cnt.
//   - One CNT_W up/down counter with hold-on-both and saturation.
//   - Instantiated 16x via generate.
// - Register array, bypass muxes and hazard logic stay in the top module.
// TESTING
// - Reset: rst=0 mid-run with cnt[3]=2 and regs[3]=0x55.
//   -> rd1(src1=3)=0 and hazard=0 immediately, before any clock edge.
// - Write/read: WB_EN=1, MEM_R_EN=0, ALU_Res=0xDEADBEEF, Dest=5, src1=5.
//   -> rd1=0xDEADBEEF in the same cycle; regs[5] holds it afterwards with WB_EN=0.
// - Select: MEM_R_EN=1, MEM_Result=0x1234, ALU_Res=0xFFFF, Dest=2.
//   -> wb_value=0x1234; regs[2]=0x1234.
// - RAW stall: issue 3 writers to r7.
//   -> cnt[7]=3.
//   -> src1=7, src1_v=1 gives hazard=1 until the third WB to r7.
//   -> In the third-WB cycle: hazard=0 and rd1=wb_value.
// - Simultaneous issue+retire on r4 with cnt[4]=1 -> cnt[4] stays 1; hazard stays 1.
// - Unused source: src2_v=0, src2 pending -> hazard=0.

Source files
------------

// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared definitions for the write-back stage: widths, register count and
// the MEM->WB bundle type shared with the pipe register.
package wb_regfile_scoreboard_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 2;
    localparam int REG_CNT = 2 ** ADDR_W;

    // Highest legal in-flight count (EX, MEM and WB each hold one writer).
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Registered MEM->WB bundle.
    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] mem_result;
        logic [ADDR_W-1:0] dest;
    } wb_bundle_t;

    // A load writes the memory data; everything else writes the ALU result.
    function automatic logic [DATA_W-1:0] wb_select(input wb_bundle_t b);
        return b.mem_r_en ? b.mem_result : b.alu_res;
    endfunction

endpackage

// File: rtl/wb_regfile_scoreboard_if.sv
// Bus between the pipeline (MEM->WB register plus ID stage) and the
// write-back register file. The master side drives write-back and issue
// information; the slave side returns read data, the write-back value,
// the RAW stall and a flat copy of the in-flight counters for observation.
//
// Handshake: there is no valid/ready pair. WB_EN qualifies the write-back
// fields in the cycle they are presented; issue_en qualifies the issue
// fields and must be held 0 by ID while hazard is 1.
interface wb_regfile_scoreboard_if;
    import wb_regfile_scoreboard_pkg::*;

    // MEM->WB write-back bundle
    logic                     WB_EN;
    logic                     MEM_R_EN;
    logic [DATA_W-1:0]        ALU_Res;
    logic [DATA_W-1:0]        MEM_Result;
    logic [ADDR_W-1:0]        Dest;

    // ID-stage issue information
    logic                     issue_en;
    logic                     issue_wb;
    logic [ADDR_W-1:0]        issue_dest;

    // ID-stage read ports
    logic [ADDR_W-1:0]        src1;
    logic [ADDR_W-1:0]        src2;
    logic                     src1_v;
    logic                     src2_v;

    // Responses
    logic [DATA_W-1:0]        rd1;
    logic [DATA_W-1:0]        rd2;
    logic [DATA_W-1:0]        wb_value;
    logic                     hazard;
    logic [REG_CNT*CNT_W-1:0] dbg_cnt;

    modport master (
        output WB_EN, MEM_R_EN, ALU_Res, MEM_Result, Dest,
        output issue_en, issue_wb, issue_dest,
        output src1, src2, src1_v, src2_v,
        input  rd1, rd2, wb_value, hazard, dbg_cnt
    );

    modport slave (
        input  WB_EN, MEM_R_EN, ALU_Res, MEM_Result, Dest,
        input  issue_en, issue_wb, issue_dest,
        input  src1, src2, src1_v, src2_v,
        output rd1, rd2, wb_value, hazard, dbg_cnt
    );

endinterface

// File: rtl/wb_scoreboard_cnt.sv
// One per-register in-flight writer counter. Counts up when a writer to this
// register issues and down when one retires; both in the same cycle leave it
// unchanged. Out-of-range steps are protocol errors: the count holds and a
// simulation assertion reports it.
module wb_scoreboard_cnt
    import wb_regfile_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    logic inc_only;
    logic dec_only;

    assign inc_only = inc && !dec;
    assign dec_only = dec && !inc;

    // Up/down count with hold on simultaneous events and saturation at both ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc_only && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec_only && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // A fourth in-flight writer means ID issued past a full scoreboard.
    cnt_overflow_a: assert property (
        @(posedge clk) disable iff (!rst) !(inc_only && (cnt == CNT_MAX))
    ) else $error("wb_scoreboard_cnt: increment at maximum count");

    // A retirement with nothing in flight means WB_EN without a matching issue.
    cnt_underflow_a: assert property (
        @(posedge clk) disable iff (!rst) !(dec_only && (cnt == '0))
    ) else $error("wb_scoreboard_cnt: decrement at zero count");

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Write-back end of the pipeline: selects the write-back value, writes the
// 16x32 register file, serves two ID read ports with same-cycle write-through
// and tracks in-flight writers per register to raise RAW stalls.
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    wb_regfile_scoreboard_if.slave bus
);

    wb_bundle_t        wb;
    logic [DATA_W-1:0] wb_value;
    logic [DATA_W-1:0] regs [REG_CNT];
    logic [CNT_W-1:0]  cnt  [REG_CNT];
    logic [REG_CNT-1:0] inc_vec;
    logic [REG_CNT-1:0] dec_vec;
    logic              hit1;
    logic              hit2;
    logic [CNT_W-1:0]  left1;
    logic [CNT_W-1:0]  left2;
    logic              pend1;
    logic              pend2;
    logic              hazard;

    assign wb.wb_en      = bus.WB_EN;
    assign wb.mem_r_en   = bus.MEM_R_EN;
    assign wb.alu_res    = bus.ALU_Res;
    assign wb.mem_result = bus.MEM_Result;
    assign wb.dest       = bus.Dest;

    // The value is presented whether or not this cycle actually writes.
    assign wb_value     = wb_select(wb);
    assign bus.wb_value = wb_value;

    // Register file: one write port, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb.wb_en) begin
            regs[wb.dest] <= wb_value;
        end
    end

    // Same-cycle write hits on each read port.
    assign hit1 = wb.wb_en && (wb.dest == bus.src1);
    assign hit2 = wb.wb_en && (wb.dest == bus.src2);

    // Read ports with zero-latency write-through of the retiring value.
    always_comb begin
        bus.rd1 = regs[bus.src1];
        bus.rd2 = regs[bus.src2];
        if (hit1) begin
            bus.rd1 = wb_value;
        end
        if (hit2) begin
            bus.rd2 = wb_value;
        end
    end

    // Writers still outstanding after this cycle's retirement; a last writer
    // retiring now is covered by the bypass above and does not stall ID.
    assign left1  = cnt[bus.src1] - {{(CNT_W-1){1'b0}}, hit1};
    assign left2  = cnt[bus.src2] - {{(CNT_W-1){1'b0}}, hit2};
    assign pend1  = bus.src1_v && (left1 != '0);
    assign pend2  = bus.src2_v && (left2 != '0);
    assign hazard = pend1 || pend2;
    assign bus.hazard = hazard;

    // Decode issue and retirement events into one-hot counter strobes.
    // An issue only counts when ID is not being stalled.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (bus.issue_en && bus.issue_wb && !hazard) begin
            inc_vec[bus.issue_dest] = 1'b1;
        end
        if (wb.wb_en) begin
            dec_vec[wb.dest] = 1'b1;
        end
    end

    for (genvar g = 0; g < REG_CNT; g++) begin : g_cnt
        wb_scoreboard_cnt u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc_vec[g]),
            .dec (dec_vec[g]),
            .cnt (cnt[g])
        );
    end

    // Flatten the counters for observation; register r sits at bits [2r+1:2r].
    always_comb begin
        bus.dbg_cnt = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            bus.dbg_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Bench for the write-back register file and scoreboard. Stimulus is applied
// just after each rising edge; the expected response for that cycle is
// computed from a behavioural model and queued, and a monitor on the falling
// edge pops and compares it with what the design presents.
module tb_wb_regfile_scoreboard;
    import wb_regfile_scoreboard_pkg::*;

    localparam int EXP_W = 3 * DATA_W + 1 + REG_CNT * CNT_W;

    logic clk;
    logic rst;

    wb_regfile_scoreboard_if bus ();

    wb_regfile_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: register contents and number of writers in flight.
    logic [DATA_W-1:0] m_regs [REG_CNT];
    int                m_pend [REG_CNT];

    logic [EXP_W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic logic model_hazard(input logic [ADDR_W-1:0] s1, input logic s1v,
                                          input logic [ADDR_W-1:0] s2, input logic s2v,
                                          input logic we, input logic [ADDR_W-1:0] d);
        int left1;
        int left2;
        left1 = m_pend[s1] - ((we && d == s1) ? 1 : 0);
        left2 = m_pend[s2] - ((we && d == s2) ? 1 : 0);
        return (s1v && left1 != 0) || (s2v && left2 != 0);
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic we, input logic mr,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem,
                        input logic [ADDR_W-1:0] d,
                        input logic ie, input logic iw, input logic [ADDR_W-1:0] id,
                        input logic [ADDR_W-1:0] s1, input logic s1v,
                        input logic [ADDR_W-1:0] s2, input logic s2v);
        logic [DATA_W-1:0] wbv;
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic              haz;
        logic [REG_CNT*CNT_W-1:0] ecnt;
        rst            = r;
        bus.WB_EN      = we;
        bus.MEM_R_EN   = mr;
        bus.ALU_Res    = alu;
        bus.MEM_Result = mem;
        bus.Dest       = d;
        bus.issue_en   = ie;
        bus.issue_wb   = iw;
        bus.issue_dest = id;
        bus.src1       = s1;
        bus.src1_v     = s1v;
        bus.src2       = s2;
        bus.src2_v     = s2v;
        if (!r) begin
            for (int i = 0; i < REG_CNT; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 0;
            end
        end
        wbv = mr ? mem : alu;
        e1  = (we && d == s1) ? wbv : m_regs[s1];
        e2  = (we && d == s2) ? wbv : m_regs[s2];
        haz = model_hazard(s1, s1v, s2, s2v, we, d);
        for (int i = 0; i < REG_CNT; i++) begin
            ecnt[i*CNT_W +: CNT_W] = CNT_W'(m_pend[i]);
        end
        exp_q.push_back({e1, e2, wbv, haz, ecnt});
        @(posedge clk);
        if (r) begin
            if (we) begin
                m_regs[d] = wbv;
                m_pend[d] = m_pend[d] - 1;
            end
            if (ie && iw && !haz) begin
                m_pend[id] = m_pend[id] + 1;
            end
        end
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] id);
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, id, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic wb_alu(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v,
                          input logic [ADDR_W-1:0] s1, input logic s1v);
        step(1'b1, 1'b1, 1'b0, v, $urandom, d, 1'b0, 1'b0, '0, s1, s1v, '0, 1'b0);
    endtask

    task automatic read(input logic [ADDR_W-1:0] s1, input logic s1v,
                        input logic [ADDR_W-1:0] s2, input logic s2v);
        step(1'b1, 1'b0, 1'b0, $urandom, $urandom, '0, 1'b0, 1'b0, '0, s1, s1v, s2, s2v);
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rd1",      bus.rd1,      e[EXP_W-1 -: DATA_W]);
            check("rd2",      bus.rd2,      e[EXP_W-1-DATA_W -: DATA_W]);
            check("wb_value", bus.wb_value, e[EXP_W-1-2*DATA_W -: DATA_W]);
            check("hazard",   {31'b0, bus.hazard}, {31'b0, e[REG_CNT*CNT_W]});
            check("cnt",      bus.dbg_cnt,  e[REG_CNT*CNT_W-1:0]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [ADDR_W-1:0] s1, s2, d, id;
        logic s1v, s2v, we, ie, iw, mr, haz, found;
        int start;

        rst = 1'b0;
        bus.WB_EN = 1'b0; bus.MEM_R_EN = 1'b0; bus.ALU_Res = '0; bus.MEM_Result = '0;
        bus.Dest = '0; bus.issue_en = 1'b0; bus.issue_wb = 1'b0; bus.issue_dest = '0;
        bus.src1 = '0; bus.src2 = '0; bus.src1_v = 1'b0; bus.src2_v = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 4'd3, 1'b1, 4'd9, 1'b1);

        // Write with same-cycle read-through, then read back from the array
        issue(4'd5);
        wb_alu(4'd5, 32'hDEADBEEF, 4'd5, 1'b0);
        read(4'd5, 1'b0, 4'd0, 1'b0);

        // Load data selected over ALU result
        issue(4'd2);
        step(1'b1, 1'b1, 1'b1, 32'h0000FFFF, 32'h00001234, 4'd2,
             1'b0, 1'b0, '0, 4'd2, 1'b0, 4'd2, 1'b0);
        read(4'd0, 1'b0, 4'd2, 1'b0);

        // RAW stall: three writers to r7 retire one by one
        issue(4'd7);
        issue(4'd7);
        issue(4'd7);
        read(4'd7, 1'b1, 4'd0, 1'b0);
        wb_alu(4'd7, 32'h0000_0071, 4'd7, 1'b1);
        wb_alu(4'd7, 32'h0000_0072, 4'd7, 1'b1);
        wb_alu(4'd7, 32'h0000_0073, 4'd7, 1'b1);
        read(4'd7, 1'b1, 4'd7, 1'b1);

        // Simultaneous issue and retire on r4 with one writer in flight
        issue(4'd4);
        step(1'b1, 1'b1, 1'b0, 32'h0000_0044, '0, 4'd4, 1'b1, 1'b1, 4'd4, '0, 1'b0, '0, 1'b0);
        read(4'd4, 1'b1, 4'd0, 1'b0);

        // Pending register on an unused source does not stall
        read(4'd1, 1'b1, 4'd4, 1'b0);

        // Mid-run reset with two writers pending on r3 holding 0x55
        issue(4'd3);
        issue(4'd3);
        issue(4'd3);
        wb_alu(4'd3, 32'h0000_0055, 4'd0, 1'b0);
        read(4'd3, 1'b1, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 4'd3, 1'b1, 4'd4, 1'b1);
        read(4'd3, 1'b1, 4'd4, 1'b1);

        // Randomized traffic that respects the issue/retire protocol
        for (int n = 0; n < 400; n++) begin
            s1  = ADDR_W'($urandom_range(0, REG_CNT - 1));
            s2  = ADDR_W'($urandom_range(0, REG_CNT - 1));
            s1v = 1'($urandom_range(0, 1));
            s2v = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            we  = 1'b0;
            d   = ADDR_W'($urandom_range(0, REG_CNT - 1));
            found = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, REG_CNT - 1);
                for (int k = 0; k < REG_CNT; k++) begin
                    if (!found && m_pend[(start + k) % REG_CNT] > 0) begin
                        found = 1'b1;
                        d = ADDR_W'((start + k) % REG_CNT);
                    end
                end
                we = found;
            end
            haz = model_hazard(s1, s1v, s2, s2v, we, d);
            id  = ADDR_W'($urandom_range(0, REG_CNT - 1));
            iw  = ($urandom_range(0, 3) != 0);
            ie  = !haz && ($urandom_range(0, 1) == 1) && (m_pend[id] < 3);
            step(1'b1, we, mr, $urandom, $urandom, d, ie, iw, id, s1, s1v, s2, s2v);
        end

        // Let the monitor finish any outstanding comparisons
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
